// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: two-flop sync, per-channel glitch filter, Gray-code
// step/direction decode with illegal-transition flagging and a wrap-around position.
module quad_step_decoder #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             hold,
    input  logic             clear,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_sticky,
    output logic             ready,
    output logic [WIDTH-1:0] position
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned INIT_W = 5;
    localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(FILTER_CYCLES);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILTER_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    // Channel vectors are packed {A, B}: bit 1 = A, bit 0 = B.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            filt_q, filt_d;
    logic [1:0][CNT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [1:0]            prev_q, prev_d;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
    state_e                state_q, state_d;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;
    logic                  ready_q, ready_d;
    logic [WIDTH-1:0]      pos_q, pos_d;

    logic [1:0]            delta_c;
    logic                  up_c;
    logic [CNT_W-1:0]      cnt_inc_c [2];

    // Synchroniser always samples, even while disabled.
    always_comb begin
        sync1_d = {quad_a, quad_b};
        sync2_d = sync1_q;
    end

    // Filter: a channel only follows the synced level after FILTER_CYCLES mismatching cycles.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_inc_c[i] = CNT_W'(flt_cnt_q[i] + CNT_W'(1));
            if (ena) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_inc_c[i] == FILT_LAST) begin
                        filt_d[i]    = sync2_q[i];
                        flt_cnt_d[i] = '0;
                    end else begin
                        flt_cnt_d[i] = cnt_inc_c[i];
                    end
                end else begin
                    flt_cnt_d[i] = '0;
                end
            end
        end
    end

    // Exactly one bit changed: up when previous A differs from current B.
    assign delta_c = prev_q ^ filt_q;
    assign up_c    = prev_q[1] ^ filt_q[0];

    // Decode FSM: INIT lets the filters settle, TRACK decodes transitions.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        dir_d      = dir_q;
        sticky_d   = sticky_q;
        ready_d    = ready_q;
        pos_d      = pos_q;

        case (state_q)
            ST_INIT: begin
                ready_d = 1'b0;
                if (ena) begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d    = ST_TRACK;
                        init_cnt_d = '0;
                        prev_d     = filt_q;
                        ready_d    = 1'b1;
                    end else begin
                        init_cnt_d = INIT_W'(init_cnt_q + INIT_W'(1));
                    end
                end
            end
            ST_TRACK: begin
                ready_d = 1'b1;
                if (ena) begin
                    prev_d = filt_q;
                    if (delta_c == 2'b11) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end else if (delta_c != 2'b00) begin
                        step_d = 1'b1;
                        dir_d  = up_c;
                        if (!hold) begin
                            pos_d = up_c ? WIDTH'(pos_q + WIDTH'(1))
                                         : WIDTH'(pos_q - WIDTH'(1));
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
                ready_d    = 1'b0;
            end
        endcase

        if (clear) begin
            pos_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            flt_cnt_q  <= '0;
            prev_q     <= '0;
            init_cnt_q <= '0;
            state_q    <= ST_INIT;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            ready_q    <= 1'b0;
            pos_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            prev_q     <= prev_d;
            init_cnt_q <= init_cnt_d;
            state_q    <= state_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            ready_q    <= ready_d;
            pos_q      <= pos_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign ready      = ready_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (WIDTH=8, FILTER_CYCLES=4).
module tb_quad_step_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       quad_a;
    logic       quad_b;
    logic       hold;
    logic       clear;
    logic       step;
    logic       dir;
    logic       err;
    logic       err_sticky;
    logic       ready;
    logic [7:0] position;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    int err_cnt = 0;

    quad_step_decoder #(
        .WIDTH        (8),
        .FILTER_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .quad_a    (quad_a),
        .quad_b    (quad_b),
        .hold      (hold),
        .clear     (clear),
        .step      (step),
        .dir       (dir),
        .err       (err),
        .err_sticky(err_sticky),
        .ready     (ready),
        .position  (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (step) step_cnt++;
            if (err)  err_cnt++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic move(input logic a, input logic b);
        quad_a = a;
        quad_b = b;
        tick(10);
    endtask

    // Edges until the named output rises; 0 if it never does within the budget.
    task automatic wait_step(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (step) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (ready) begin
                lat = i;
                break;
            end
        end
    endtask

    logic [1:0] up_seq [16];
    int lat;
    int s0;
    int e0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: up_seq[i] = 2'b01;
                1: up_seq[i] = 2'b11;
                2: up_seq[i] = 2'b10;
                default: up_seq[i] = 2'b00;
            endcase
        end

        rst_n = 1'b0; ena = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
        hold = 1'b0; clear = 1'b0;
        tick(3);
        check("rst_ready", int'(ready), 0);
        check("rst_pos", int'(position), 0);
        check("rst_step", int'(step), 0);
        check("rst_err", int'(err), 0);
        check("rst_sticky", int'(err_sticky), 0);
        check("rst_dir", int'(dir), 0);

        rst_n = 1'b1;
        wait_ready(lat);
        check("ready_latency", lat, 6);
        tick(4);
        check("init_pos", int'(position), 0);
        check("init_steps", step_cnt, 0);
        check("init_errs", err_cnt, 0);

        // Four full up cycles, first transition timed.
        s0 = step_cnt;
        quad_a = up_seq[0][1];
        quad_b = up_seq[0][0];
        wait_step(lat);
        check("step_latency", lat, 7);
        tick(5);
        for (int i = 1; i < 16; i++) move(up_seq[i][1], up_seq[i][0]);
        check("up_steps", step_cnt - s0, 16);
        check("up_dir", int'(dir), 1);
        check("up_pos", int'(position), 16);
        check("up_errs", err_cnt, 0);

        // Wrap both ways.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_pos", int'(position), 0);
        move(1'b1, 1'b0);
        check("wrap_down_pos", int'(position), 255);
        check("wrap_down_dir", int'(dir), 0);
        move(1'b0, 1'b0);
        check("wrap_up_pos", int'(position), 0);
        check("wrap_up_dir", int'(dir), 1);

        // Glitch filtering from state 01.
        move(1'b0, 1'b1);
        check("pre_glitch_pos", int'(position), 1);
        s0 = step_cnt;
        quad_a = 1'b1;
        tick(3);
        quad_a = 1'b0;
        tick(12);
        check("glitch3_steps", step_cnt - s0, 0);
        check("glitch3_pos", int'(position), 1);
        s0 = step_cnt;
        quad_a = 1'b1;
        tick(4);
        quad_a = 1'b0;
        tick(12);
        check("pulse4_steps", step_cnt - s0, 2);
        check("pulse4_pos", int'(position), 1);
        check("pulse4_dir", int'(dir), 0);

        // Illegal double change 01 -> 10.
        s0 = step_cnt;
        e0 = err_cnt;
        move(1'b1, 1'b0);
        check("illegal_err", err_cnt - e0, 1);
        check("illegal_sticky", int'(err_sticky), 1);
        check("illegal_steps", step_cnt - s0, 0);
        check("illegal_pos", int'(position), 1);
        check("illegal_dir", int'(dir), 0);

        // Up step 10 -> 00 lands on the same edge as clear.
        quad_a = 1'b0;
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_step_pulse", int'(step), 1);
        check("clr_step_pos", int'(position), 0);
        check("clr_step_sticky", int'(err_sticky), 0);
        check("clr_step_dir", int'(dir), 1);
        tick(5);
        check("clr_step_pos_after", int'(position), 0);

        // Hold: steps reported, position frozen.
        hold = 1'b1;
        s0 = step_cnt;
        for (int i = 0; i < 5; i++) move(up_seq[i][1], up_seq[i][0]);
        hold = 1'b0;
        check("hold_steps", step_cnt - s0, 5);
        check("hold_pos", int'(position), 0);
        check("hold_dir", int'(dir), 1);

        // Disabled during a transition 01 -> 11.
        s0 = step_cnt;
        ena = 1'b0;
        quad_a = 1'b1;
        tick(15);
        check("ena_off_steps", step_cnt - s0, 0);
        check("ena_off_pos", int'(position), 0);
        check("ena_off_ready", int'(ready), 1);
        ena = 1'b1;
        tick(10);
        check("ena_on_steps", step_cnt - s0, 1);
        check("ena_on_pos", int'(position), 1);

        // Mid-operation reset returns to INIT.
        rst_n = 1'b0;
        quad_a = 1'b0;
        quad_b = 1'b0;
        #1;
        check("midrst_pos", int'(position), 0);
        check("midrst_ready", int'(ready), 0);
        tick(2);
        rst_n = 1'b1;
        e0 = err_cnt;
        wait_ready(lat);
        check("midrst_ready_latency", lat, 6);
        tick(10);
        check("midrst_errs", err_cnt - e0, 0);
        check("midrst_sticky", int'(err_sticky), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
